fpalu_divider: RTL and testbench

- Iterative IEEE-754 single-precision divider; computes quotient = A / B.
- Complements the combinational adder/multiplier pair in the FP ALU. Division is the inverse of the multiply path and runs multi-cycle with a start/done handshake.
- Sits beside the ALU and shares the A/B operand buses. The result is registered and held until the next operation.

---
 rtl/fpalu_divider.sv | 193 +++++++++++++++++++
 tb/tb_fpalu_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_divider.sv
// fpalu_divider: iterative IEEE-754 single-precision divider, one restoring quotient bit per clock.
// Build option: define FPALU_DIV_ROUND_NEAREST_EN for round-to-nearest-even (default truncates toward zero).
module fpalu_divider #(
    parameter int QBITS = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);

`ifdef FPALU_DIV_ROUND_NEAREST_EN
    localparam logic ROUND_NEAREST = 1'b1;
`else
    localparam logic ROUND_NEAREST = 1'b0;
`endif
    localparam int CW = $clog2(QBITS);

    typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, NORM, DONE} state_t;

    state_t              state_reg, state_next;
    logic [31:0]         a_reg, b_reg;
    logic                sign_reg;
    logic                special_reg;
    logic signed [9:0]   exp_reg;
    logic [24:0]         rem_reg;
    logic [23:0]         dvs_reg;
    logic [QBITS-1:0]    q_reg;
    logic [CW-1:0]       count_reg;
    logic [31:0]         quotient_reg;
    logic                overflow_reg, underflow_reg, div_by_zero_reg, invalid_reg;

    // Operand classification; exponent field 0 counts as zero (denormals flushed)
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
    assign a_zero = (a_reg[30:23] == 8'd0);
    assign b_zero = (b_reg[30:23] == 8'd0);
    assign a_inf  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
    assign b_inf  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
    assign a_nan  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
    assign b_nan  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
    assign sign   = a_reg[31] ^ b_reg[31];

    logic        spec_hit, spec_inv, spec_dbz;
    logic [31:0] spec_q;

    always_comb begin
        spec_hit = 1'b1;
        spec_q   = 32'h7FC00000;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_q = {sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_q   = {sign, 8'hFF, 23'd0};
            spec_dbz = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_q = {sign, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Restoring step: remainder stays below 2*divisor, so bit 24 of the difference is its sign
    logic [24:0] rem_diff;
    logic        rem_ge;
    logic [23:0] rem_kept;
    assign rem_diff = rem_reg - {1'b0, dvs_reg};
    assign rem_ge   = ~rem_diff[24];
    assign rem_kept = rem_ge ? rem_diff[23:0] : rem_reg[23:0];

    logic [23:0]       sig;
    logic              guard, sticky, round_up;
    logic [24:0]       sig_r;
    logic signed [9:0] exp_n, exp_r;
    logic [22:0]       frac;

    always_comb begin
        if (q_reg[QBITS-1]) begin
            sig    = q_reg[QBITS-1:2];
            guard  = q_reg[1];
            sticky = q_reg[0] | (rem_reg != 25'd0);
            exp_n  = exp_reg;
        end else begin
            sig    = q_reg[QBITS-2:1];
            guard  = q_reg[0];
            sticky = (rem_reg != 25'd0);
            exp_n  = exp_reg - 10'sd1;
        end
        round_up = ROUND_NEAREST & guard & (sticky | sig[0]);
        sig_r    = {1'b0, sig} + {24'd0, round_up};
        exp_r    = exp_n + (sig_r[24] ? 10'sd1 : 10'sd0);
        frac     = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
    end

    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Special cases still pass through NORM so their latency is a fixed two cycles
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = spec_hit ? NORM : DIVIDE;
            DIVIDE:  if (count_reg == CW'(QBITS - 1)) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg           <= 32'd0;
            b_reg           <= 32'd0;
            sign_reg        <= 1'b0;
            special_reg     <= 1'b0;
            exp_reg         <= 10'sd0;
            rem_reg         <= 25'd0;
            dvs_reg         <= 24'd0;
            q_reg           <= '0;
            count_reg       <= '0;
            quotient_reg    <= 32'd0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
            div_by_zero_reg <= 1'b0;
            invalid_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    a_reg           <= A;
                    b_reg           <= B;
                    overflow_reg    <= 1'b0;
                    underflow_reg   <= 1'b0;
                    div_by_zero_reg <= 1'b0;
                    invalid_reg     <= 1'b0;
                end
                CHECK: begin
                    sign_reg    <= sign;
                    special_reg <= spec_hit;
                    if (spec_hit) begin
                        quotient_reg    <= spec_q;
                        invalid_reg     <= spec_inv;
                        div_by_zero_reg <= spec_dbz;
                    end else begin
                        rem_reg   <= {2'b01, a_reg[22:0]};
                        dvs_reg   <= {1'b1, b_reg[22:0]};
                        exp_reg   <= $signed({2'b00, a_reg[30:23]}) - $signed({2'b00, b_reg[30:23]}) + 10'sd127;
                        q_reg     <= '0;
                        count_reg <= '0;
                    end
                end
                DIVIDE: begin
                    q_reg     <= {q_reg[QBITS-2:0], rem_ge};
                    rem_reg   <= {rem_kept, 1'b0};
                    count_reg <= count_reg + CW'(1);
                end
                NORM: if (!special_reg) begin
                    if (exp_r >= 10'sd255) begin
                        quotient_reg <= {sign_reg, 8'hFF, 23'd0};
                        overflow_reg <= 1'b1;
                    end else if (exp_r <= 10'sd0) begin
                        quotient_reg  <= {sign_reg, 31'd0};
                        underflow_reg <= 1'b1;
                    end else begin
                        quotient_reg <= {sign_reg, exp_r[7:0], frac};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign div_by_zero = div_by_zero_reg;
    assign invalid     = invalid_reg;

endmodule

// File: tb/tb_fpalu_divider.sv
// tb_fpalu_divider: scoreboard bench for fpalu_divider; expected results are queued at issue and checked at done.
module tb_fpalu_divider;

    localparam int LIMIT = 60;

`ifdef FPALU_DIV_ROUND_NEAREST_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done, overflow, underflow, div_by_zero, invalid;
    logic [31:0] quotient;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fpalu_divider #(.QBITS(26)) dut (
        .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .quotient(quotient),
        .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clock = ~clock;

    // Queue the expectation, then pulse start for one edge (edge N)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [3:0] f, input int lat);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.f = f; e.lat = lat;
        sb.push_back(e);
        @(negedge clock);
        A = a; B = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts edges after edge N until done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < LIMIT) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL reset_quotient got=%08h want=00000000", quotient); end
        checks++; if ({overflow, underflow, div_by_zero, invalid} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {overflow, underflow, div_by_zero, invalid});
        end
        reset = 1'b0;
        $display("reset released");
    endtask

    // Normal operands: 28-cycle latency
    task automatic test_normal();
        logic [31:0] ta [4] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hC0C00000};
        logic [31:0] tb [4] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40000000};
        logic [31:0] tq [4] = '{32'h40400000, THIRD,        32'h3F800000, 32'hC0400000};
        int lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], tq[i], 4'b0000, 28);
            wait_done(lat);
            e = sb.pop_front();
            $display("normal a=%08h b=%08h q=%08h flags=%b lat=%0d", e.a, e.b, quotient,
                     {overflow, underflow, div_by_zero, invalid}, lat);
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL normal_latency got=%0d want=%0d", lat, e.lat); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL normal_quotient got=%08h want=%08h", quotient, e.q); end
            checks++; if ({overflow, underflow, div_by_zero, invalid} !== e.f) begin
                failures++; $display("FAIL normal_flags got=%b want=%b", {overflow, underflow, div_by_zero, invalid}, e.f);
            end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL normal_busy_at_done got=%b want=1", busy); end
            @(negedge clock);
            checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL normal_idle_after got=%b want=00", {busy, done}); end
        end
    endtask

    // Special cases: two-cycle latency
    task automatic test_special();
        logic [31:0] ta [6] = '{32'hBF800000, 32'h00000000, 32'h7F800000, 32'h40000000, 32'h7FC00001, 32'h00000000};
        logic [31:0] tb [6] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'hFF800000, 32'h3F800000, 32'hC0000000};
        logic [31:0] tq [6] = '{32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h80000000};
        logic [3:0]  tf [6] = '{4'b0010,      4'b0001,      4'b0000,      4'b0000,      4'b0001,      4'b0000};
        int lat;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], tq[i], tf[i], 2);
            wait_done(lat);
            e = sb.pop_front();
            $display("special a=%08h b=%08h q=%08h flags=%b lat=%0d", e.a, e.b, quotient,
                     {overflow, underflow, div_by_zero, invalid}, lat);
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL special_latency got=%0d want=%0d", lat, e.lat); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL special_quotient got=%08h want=%08h", quotient, e.q); end
            checks++; if ({overflow, underflow, div_by_zero, invalid} !== e.f) begin
                failures++; $display("FAIL special_flags got=%b want=%b", {overflow, underflow, div_by_zero, invalid}, e.f);
            end
            @(negedge clock);
            checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL special_idle_after got=%b want=00", {busy, done}); end
        end
    endtask

    // Exponent range limits
    task automatic test_range();
        logic [31:0] ta [2] = '{32'h7F000000, 32'h00800000};
        logic [31:0] tb [2] = '{32'h00800000, 32'h7F000000};
        logic [31:0] tq [2] = '{32'h7F800000, 32'h00000000};
        logic [3:0]  tf [2] = '{4'b1000,      4'b0100};
        int lat;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], tq[i], tf[i], 28);
            wait_done(lat);
            e = sb.pop_front();
            $display("range a=%08h b=%08h q=%08h flags=%b lat=%0d", e.a, e.b, quotient,
                     {overflow, underflow, div_by_zero, invalid}, lat);
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL range_latency got=%0d want=%0d", lat, e.lat); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL range_quotient got=%08h want=%08h", quotient, e.q); end
            checks++; if ({overflow, underflow, div_by_zero, invalid} !== e.f) begin
                failures++; $display("FAIL range_flags got=%b want=%b", {overflow, underflow, div_by_zero, invalid}, e.f);
            end
        end
    endtask

    // start held high with new operands while busy must be ignored
    task automatic test_back_to_back();
        int lat;
        exp_t e;
        e.a = 32'h40C00000; e.b = 32'h40000000; e.q = 32'h40400000; e.f = 4'b0000; e.lat = 28;
        sb.push_back(e);
        @(negedge clock);
        A = e.a; B = e.b; start = 1'b1;
        @(negedge clock);
        A = 32'h3F800000; B = 32'h40400000;
        lat = 0;
        while (!done && lat < LIMIT) begin
            @(negedge clock);
            lat++;
            if (lat == 20) start = 1'b0;
        end
        e = sb.pop_front();
        $display("back_to_back a=%08h b=%08h q=%08h lat=%0d", e.a, e.b, quotient, lat);
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, e.lat); end
        checks++; if (quotient !== e.q) begin failures++; $display("FAIL b2b_quotient got=%08h want=%08h", quotient, e.q); end
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_restart got=%b want=0", busy); end
    endtask

    // Reset at edge N+10 aborts with no done; a later start completes normally
    task automatic test_abort();
        int lat;
        int seen;
        exp_t e;
        @(negedge clock);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        $display("abort at edge N+10 busy=%b done=%b q=%08h", busy, done, quotient);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL abort_quotient got=%08h want=00000000", quotient); end
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", seen); end
        issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
        wait_done(lat);
        e = sb.pop_front();
        $display("after_abort a=%08h b=%08h q=%08h lat=%0d", e.a, e.b, quotient, lat);
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL after_abort_latency got=%0d want=%0d", lat, e.lat); end
        checks++; if (quotient !== e.q) begin failures++; $display("FAIL after_abort_quotient got=%08h want=%08h", quotient, e.q); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_back_to_back();
        test_abort();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
